// File: rtl/ssc_pkg.sv
// Shared definitions for the correlator readout scheduler: register offsets,
// drain FSM states and the record layout pushed into the record FIFO.
package ssc_pkg;

  localparam logic [15:0] OFF_CNT = 16'h06a0;
  localparam logic [15:0] OFF_LO  = 16'h06a4;
  localparam logic [15:0] OFF_HI  = 16'h06a8;
  localparam logic [15:0] OFF_ST  = 16'h06ac;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    RD_LO,
    RD_HI,
    RD_ST,
    GAP
  } state_t;

  typedef struct packed {
    logic [3:0]  ch;
    logic [31:0] cnt;
    logic [63:0] corr;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  // Register offset read in each drain state; zero when no read is issued.
  function automatic logic [15:0] state_offset(input state_t s);
    case (s)
      RD_CNT:  return OFF_CNT;
      RD_LO:   return OFF_LO;
      RD_HI:   return OFF_HI;
      RD_ST:   return OFF_ST;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/corr_rec_fifo.sv
// Record FIFO, DEPTH entries, first-word-fall-through read port.
// Push and pop take effect at the rising edge; pushing when full is ignored.
module corr_rec_fifo #(
  parameter int W     = 100,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               rd_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: the read side is qualified by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ssc_readout_sched.sv
// Shares the channel register bus between the host (priority, same-cycle) and a
// round-robin drain engine that reads Cnt/Low/High/Status and queues a record.
module ssc_readout_sched
  import ssc_pkg::*;
#(
  parameter int NCH   = 16,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sched_en,
  input  logic              host_read,
  input  logic              host_write,
  input  logic [31:0]       host_addr,
  input  logic [31:0]       host_wdata,
  output logic [31:0]       host_rdata,
  output logic [31:0]       ch_addr,
  output logic [31:0]       ch_wdata,
  output logic [NCH-1:0]    ch_read,
  output logic [NCH-1:0]    ch_write,
  input  logic [NCH*32-1:0] ch_rdata,
  input  logic [NCH-1:0]    cseen,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [3:0]        rec_ch,
  output logic [31:0]       rec_cnt,
  output logic [63:0]       rec_corr
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [3:0]    sel;
  logic [3:0]    rr_ptr;
  logic [31:0]   cnt_q;
  logic [31:0]   lo_q;
  logic [31:0]   hi_q;

  logic          host_stb;
  logic [7:0]    host_ch;
  logic          host_hit;
  logic [31:0]   sel_dat;
  logic [3:0]    win;
  logic          win_vld;
  logic          start;
  logic          push;
  rec_t          push_rec;
  rec_t          head_rec;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;

  assign host_stb = host_read | host_write;
  assign host_ch  = host_addr[23:16];
  assign host_hit = host_ch < 8'(NCH);
  assign sel_dat  = ch_rdata[32*sel +: 32];

  assign host_rdata = (host_read && host_hit) ? ch_rdata[32*host_ch[3:0] +: 32] : 32'h0;

  // First pending channel at or above rr_ptr, wrapping at NCH.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!win_vld && cseen[idx]) begin
        win_vld = 1'b1;
        win     = 4'(idx);
      end
    end
  end

  assign start = (state == IDLE) && sched_en && win_vld && !host_stb &&
                 (fifo_cnt < CW'(DEPTH));
  assign push  = (state == RD_ST) && !host_stb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
      cnt_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sel    <= win;
          rr_ptr <= (int'(win) == NCH-1) ? 4'd0 : win + 4'd1;
          state  <= RD_CNT;
        end
        RD_CNT: if (!host_stb) begin
          cnt_q <= sel_dat;
          state <= RD_LO;
        end
        RD_LO: if (!host_stb) begin
          lo_q  <= sel_dat;
          state <= RD_HI;
        end
        RD_HI: if (!host_stb) begin
          hi_q  <= sel_dat;
          state <= RD_ST;
        end
        // Status data is not kept; the read itself clears the channel flag.
        RD_ST: if (!host_stb) state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Host owns the bus for any cycle it strobes; the drain engine stalls.
  always_comb begin
    ch_addr  = '0;
    ch_wdata = '0;
    ch_read  = '0;
    ch_write = '0;
    if (host_stb) begin
      ch_addr  = {16'h0000, host_addr[15:0]};
      ch_wdata = host_wdata;
      if (host_hit) begin
        ch_read[host_ch[3:0]]  = host_read;
        ch_write[host_ch[3:0]] = host_write;
      end
    end else if (state inside {RD_CNT, RD_LO, RD_HI, RD_ST}) begin
      ch_addr      = {16'h0000, state_offset(state)};
      ch_read[sel] = 1'b1;
    end
  end

  assign push_rec.ch   = sel;
  assign push_rec.cnt  = cnt_q;
  assign push_rec.corr = {hi_q, lo_q};

  corr_rec_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_rec),
    .pop      (rec_valid && rec_ready),
    .rd_dat   (head_rec),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign rec_valid = !fifo_empty;
  assign rec_ch    = fifo_empty ? 4'h0  : head_rec.ch;
  assign rec_cnt   = fifo_empty ? 32'h0 : head_rec.cnt;
  assign rec_corr  = fifo_empty ? 64'h0 : head_rec.corr;

  logic unused_ok;
  assign unused_ok = ^{host_addr[31:24], fifo_full};

endmodule

// File: tb/tb_ssc_readout_sched.sv
// Directed bench for ssc_readout_sched with a behavioural channel array model.
module tb_ssc_readout_sched;

  localparam int NCH   = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              sched_en;
  logic              host_read;
  logic              host_write;
  logic [31:0]       host_addr;
  logic [31:0]       host_wdata;
  logic [31:0]       host_rdata;
  logic [31:0]       ch_addr;
  logic [31:0]       ch_wdata;
  logic [NCH-1:0]    ch_read;
  logic [NCH-1:0]    ch_write;
  logic [NCH*32-1:0] ch_rdata;
  logic [NCH-1:0]    cseen = '0;
  logic [NCH-1:0]    cseen_set;
  logic [NCH-1:0]    cseen_clr;
  logic              rec_valid;
  logic              rec_ready;
  logic [3:0]        rec_ch;
  logic [31:0]       rec_cnt;
  logic [63:0]       rec_corr;

  logic [31:0] cnt_mem [NCH];
  logic [31:0] lo_mem  [NCH];
  logic [31:0] hi_mem  [NCH];

  logic [3:0]  log_ch   [$];
  logic [31:0] log_cnt  [$];
  logic [63:0] log_corr [$];
  int          log_cyc  [$];
  int          cyc = 0;

  int n_checks = 0;
  int n_err    = 0;
  int base;

  ssc_readout_sched #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sched_en   (sched_en),
    .host_read  (host_read),
    .host_write (host_write),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .ch_addr    (ch_addr),
    .ch_wdata   (ch_wdata),
    .ch_read    (ch_read),
    .ch_write   (ch_write),
    .ch_rdata   (ch_rdata),
    .cseen      (cseen),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_ch     (rec_ch),
    .rec_cnt    (rec_cnt),
    .rec_corr   (rec_corr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] chan_val(input int i, input logic [15:0] off);
    case (off)
      16'h06a0: return cnt_mem[i];
      16'h06a4: return lo_mem[i];
      16'h06a8: return hi_mem[i];
      16'h06ac: return 32'h0000_0001;
      default:  return {8'hAA, 8'(i), off};
    endcase
  endfunction

  function automatic logic [63:0] exp_corr(input int i);
    return {hi_mem[i], lo_mem[i]};
  endfunction

  always_comb begin
    ch_rdata  = '0;
    cseen_clr = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_rdata[32*i +: 32] = chan_val(i, ch_addr[15:0]);
      cseen_clr[i] = ch_read[i] && (ch_addr[15:0] == 16'h06ac);
    end
  end

  // Channel flags survive scheduler reset; a Status read clears them.
  always @(posedge clk) cseen <= (cseen | cseen_set) & ~cseen_clr;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rec_valid && rec_ready) begin
      log_ch.push_back(rec_ch);
      log_cnt.push_back(rec_cnt);
      log_corr.push_back(rec_corr);
      log_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flag becomes visible at the next edge; returns in that cycle (T0).
  task automatic set_cseen(input logic [NCH-1:0] mask);
    cseen_set = mask;
    step();
    cseen_set = '0;
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && log_ch.size() < n; i++) step();
    check(tag, log_ch.size(), n);
  endtask

  task automatic check_rec(input string tag, input int idx, input int c);
    check({tag, "_ch"},   log_ch[idx],   c);
    check({tag, "_cnt"},  log_cnt[idx],  cnt_mem[c]);
    check({tag, "_corr"}, log_corr[idx], exp_corr(c));
  endtask

  initial begin
    logic [15:0] offs [4];
    int          ord3 [6];
    offs[0] = 16'h06a0; offs[1] = 16'h06a4; offs[2] = 16'h06a8; offs[3] = 16'h06ac;
    ord3[0] = 6; ord3[1] = 8; ord3[2] = 10; ord3[3] = 0; ord3[4] = 2; ord3[5] = 4;
    for (int i = 0; i < NCH; i++) begin
      cnt_mem[i] = 32'h0000_0100 + i;
      lo_mem[i]  = 32'hC0DE_0000 + i;
      hi_mem[i]  = 32'h0000_0070 + i;
    end
    cnt_mem[3] = 32'h0000_0010;
    lo_mem[3]  = 32'hDEAD_BEEF;
    hi_mem[3]  = 32'h0000_0001;

    rst = 1'b0; sched_en = 1'b1; rec_ready = 1'b0; cseen_set = '0;
    host_read = 1'b0; host_write = 1'b0; host_addr = '0; host_wdata = '0;
    step(); step();
    check("rst_ch_read",  ch_read,   0);
    check("rst_ch_write", ch_write,  0);
    check("rst_ch_addr",  ch_addr,   0);
    check("rst_ch_wdata", ch_wdata,  0);
    check("rst_rec_vld",  rec_valid, 0);
    check("rst_rec_corr", rec_corr,  0);
    check("rst_hrdata",   host_rdata, 0);
    rst = 1'b1;
    step();

    // Single drain of channel 3
    set_cseen(16'h0008);
    check("t1_t0_idle", ch_read, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_rd_strobe", ch_read, 16'h0008);
      check("t1_rd_offset", ch_addr, {16'h0, offs[k]});
    end
    step();
    check("t1_gap_strobe", ch_read,   0);
    check("t1_rec_valid",  rec_valid, 1);
    check("t1_rec_ch",     rec_ch,    3);
    check("t1_rec_cnt",    rec_cnt,   32'h10);
    check("t1_rec_corr",   rec_corr,  64'h0000_0001_DEAD_BEEF);
    check("t1_cseen_clr",  cseen[3],  0);
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    check("t1_popped", rec_valid, 0);

    // Move rr_ptr to 6 via channel 5, then 1/5/9 together
    rec_ready = 1'b1;
    base = log_ch.size();
    set_cseen(16'h0020);
    wait_log("t2_pre_len", base + 1, 40);
    base = log_ch.size();
    set_cseen(16'h0222);
    wait_log("t2_len", base + 3, 80);
    check_rec("t2_r0", base,     9);
    check_rec("t2_r1", base + 1, 1);
    check_rec("t2_r2", base + 2, 5);
    check("t2_gap01", log_cyc[base+1] - log_cyc[base],   6);
    check("t2_gap12", log_cyc[base+2] - log_cyc[base+1], 6);

    // FIFO full back-pressure with six pending channels
    rec_ready = 1'b0;
    base = log_ch.size();
    set_cseen(16'h0555);
    repeat (40) step();
    check("t3_no_pop",    log_ch.size(), base);
    check("t3_pending",   cseen,   16'h0014);
    check("t3_idle",      ch_read, 0);
    check("t3_head_ch",   rec_ch,  6);
    rec_ready = 1'b1;
    wait_log("t3_len", base + 6, 100);
    for (int k = 0; k < 6; k++) check_rec("t3_rec", base + k, ord3[k]);
    check("t3_all_clr", cseen, 0);

    // Host read stealing RD_HI of channel 7
    rec_ready = 1'b0;
    set_cseen(16'h0080);
    step(); step(); step();
    check("t4_rd_hi", ch_addr, 32'h06a8);
    host_read = 1'b1;
    host_addr = 32'h0002_02a4;
    #1;
    check("t4_hrdata",   host_rdata, 32'hAA02_02a4);
    check("t4_hstrobe",  ch_read,    16'h0004);
    check("t4_haddr",    ch_addr,    32'h02a4);
    step();
    host_read = 1'b0;
    #1;
    check("t4_hi_again", ch_addr, 32'h06a8);
    check("t4_hi_strb",  ch_read, 16'h0080);
    step();
    check("t4_rd_st", ch_addr, 32'h06ac);
    step();
    check("t4_rec_vld",  rec_valid, 1);
    check("t4_rec_ch",   rec_ch,    7);
    check("t4_rec_cnt",  rec_cnt,   cnt_mem[7]);
    check("t4_rec_corr", rec_corr,  exp_corr(7));

    // Reset during RD_LO of channel 4, with one record still queued
    set_cseen(16'h0010);
    step(); step();
    check("t5_rd_lo", ch_addr, 32'h06a4);
    check("t5_strb",  ch_read, 16'h0010);
    rst = 1'b0;
    #1;
    check("t5_ch_read",  ch_read,   0);
    check("t5_ch_addr",  ch_addr,   0);
    check("t5_rec_vld",  rec_valid, 0);
    check("t5_rec_ch",   rec_ch,    0);
    check("t5_rec_cnt",  rec_cnt,   0);
    check("t5_rec_corr", rec_corr,  0);
    step();
    check("t5_cseen_kept", cseen[4], 1);
    rst = 1'b1;
    base = log_ch.size();
    rec_ready = 1'b1;
    wait_log("t5_len", base + 1, 40);
    check_rec("t5_rec", base, 4);

    // Out-of-range host channel, then a plain host write
    repeat (4) step();
    host_read = 1'b1;
    host_addr = 32'h0020_06a0;
    #1;
    check("t6_no_strobe", ch_read,    0);
    check("t6_hrdata",    host_rdata, 0);
    host_read  = 1'b0;
    host_write = 1'b1;
    host_addr  = 32'h0005_0010;
    host_wdata = 32'h1234_5678;
    #1;
    check("t6_wr_strobe", ch_write, 16'h0020);
    check("t6_wr_data",   ch_wdata, 32'h1234_5678);
    check("t6_wr_addr",   ch_addr,  32'h0010);
    step();
    host_write = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ssc_readout_sched.md
# ssc_readout_sched

Readout scheduler that shares the register bus of NCH spread-spectrum correlator channels between the host and an autonomous drain engine. When a channel raises its correlation-seen flag, the block round-robin selects that channel. It reads Correlation Cnt/Low/High/Status, which clears the flag, and pushes a tagged record into an output FIFO. Host accesses pass through with priority. The block sits between the host bus and the channel array, above the per-channel correlators.

## Interface
- NCH, 16: number of correlator channels (2..16).
- DEPTH, 4: record FIFO depth (power of 2).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sched_en  in  1  enables autonomous draining.
- host_read, host_write  in  1 each  host strobes, one-cycle, never both.
- host_addr  in  32  [23:16] channel index, [15:0] register offset.
- host_wdata  in  32  host write data.
- host_rdata  out  32  read data, combinational from the addressed channel.
- ch_addr  out  32  shared channel address, offset only.
- ch_wdata  out  32  shared write data.
- ch_read, ch_write  out  NCH  one-hot per-channel strobes.
- ch_rdata  in  NCH*32  concatenated channel read data; channel i occupies [32i+31:32i].
- cseen  in  NCH  per-channel correlation-seen flags.
- rec_valid  out  1 / rec_ready  in  1  record stream handshake.
- rec_ch  out  4 / rec_cnt  out  32 / rec_corr  out  64  channel, sample count, {High,Low}.

## Operation
- FSM states: IDLE, RD_CNT (0x6a0), RD_LO (0x6a4), RD_HI (0x6a8), RD_ST (0x6ac), GAP.
- IDLE → RD_CNT requires sched_en, at least one cseen bit, FIFO count < DEPTH, and no host strobe. The winner is the first set bit at or after rr_ptr, searching upward with wrap. rr_ptr ← winner+1 mod NCH.
- Each RD_x state drives ch_addr = offset and ch_read[sel]=1. ch_rdata[sel] is captured at the closing edge into cnt/lo/hi.
- RD_ST reads the Status register, which clears the channel's flag. At its closing edge the record {sel, cnt, hi, lo} is written to the FIFO.
- GAP drives no strobe, so the channel's address-edge detect re-arms. GAP → IDLE unconditionally.
- Host priority: any host strobe in a cycle forces ch_addr/ch_wdata/ch_read/ch_write to the host values for channel host_addr[23:16]. The FSM holds its state and performs no capture that cycle.
- host_addr[23:16] ≥ NCH: no strobe is issued, and host_rdata = 0.
- FIFO full: the FSM never starts a sequence, so no record is dropped. Pending channels keep cseen high and are served later.
- sched_en deasserted mid-sequence: the sequence completes. No new sequence starts.
- Reset asserted: the FSM goes to IDLE, rr_ptr goes to 0, the FIFO empties, and all outputs go to 0. A half-read channel keeps cseen set and is re-drained after reset.

## Timing
- Reset values: every output is 0.
- Uncontended drain: cseen sampled in IDLE at T0. RD_CNT…RD_ST occupy T1–T4, GAP is T5, and rec_valid=1 from T5 (first-word-fall-through FIFO). IDLE is at T6.
- Back-to-back channels: one record per 6 cycles.
- Each host-stolen cycle adds exactly one cycle of latency.
- Record pops on rec_valid & rec_ready at the rising edge. A simultaneous push and pop on a full FIFO cannot occur, because a start is gated by the count.
- host_rdata is valid in the same cycle as host_read.

## Structure
- ssc_pkg: register offset constants (0x6a0/0x6a4/0x6a8/0x6ac), FSM state enum, and a record struct {ch[3:0], cnt[31:0], corr[63:0]}.
- Sub-module corr_rec_fifo: DEPTH×100-bit synchronous FIFO with fall-through output, full/empty/count, and async active-low reset.
- Round-robin find-first logic stays inline in the top.

## Test plan
- Channel 3 asserts cseen, channel returns Cnt=0x10, Low=0xDEADBEEF, High=0x1 → at T5 rec_ch=3, rec_cnt=0x10, rec_corr=0x00000001_DEADBEEF; ch_read[3] is asserted exactly at T1–T4 with the four offsets in order.
- Channels 1, 5 and 9 assert cseen together with rr_ptr=6 → records are emitted in order 9, 1, 5, spaced 6 cycles apart.
- rec_ready held 0 with DEPTH=4 and 6 channels pending → exactly 4 records are queued, the FSM stays in IDLE, and the remaining 2 cseen stay high. Releasing rec_ready drains all 6 with no loss.
- host_read to channel 2, offset 0x2a4, during RD_HI of channel 7 → host_rdata equals channel 2 data that cycle, RD_HI extends one cycle, and the record is correct.
- Reset pulsed during RD_LO of channel 4 → all outputs go to 0 and the FIFO is empty. After release, channel 4 is re-drained, producing a complete record.
- host_addr[23:16]=0x20 read → no ch_read asserted, host_rdata=0.
